// File: rtl/digilent_kypd_emulator_if.sv
// Key-press command channel for the PMOD KYPD emulator.
// Producer drives code/hold with valid; the emulator answers with ready.
interface digilent_kypd_emulator_if;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [3:0]  key_code_i;
    logic [15:0] key_hold_us_i;

    modport master (
        output key_valid_i,
        output key_code_i,
        output key_hold_us_i,
        input  key_ready_o
    );

    modport slave (
        input  key_valid_i,
        input  key_code_i,
        input  key_hold_us_i,
        output key_ready_o
    );
endinterface

// File: rtl/digilent_kypd_emulator.sv
// Digilent PMOD KYPD keypad-side emulator: queued key presses close matrix contacts.
// Define KYPD_EMU_BOUNCE_EN to add press/release contact-bounce windows.
module digilent_kypd_emulator #(
    parameter real ClockFrequencyInMHz = 100.0,
    parameter int  ReleaseGapCycles    = 1000,
    parameter int  BounceCycles        = 64,
    parameter int  FifoDepth           = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [3:0]                     kypd_cols_i,
    output logic [3:0]                     kypd_rows_o,
    digilent_kypd_emulator_if.slave        key_if,
    output logic                           pressed_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int CyclesPerUs = int'(ClockFrequencyInMHz);
    localparam int HoldW       = $clog2(65535 * CyclesPerUs + 1);
    localparam int GapW        = $clog2(ReleaseGapCycles + 1);
    localparam int BncW        = $clog2(BounceCycles + 1);
    localparam int MaxHG       = (HoldW > GapW) ? HoldW : GapW;
    localparam int CntW        = (MaxHG > BncW) ? MaxHG : BncW;
    localparam int PtrW        = $clog2(FifoDepth);

    localparam logic [CntW-1:0] GapLast = CntW'(ReleaseGapCycles - 1);
`ifdef KYPD_EMU_BOUNCE_EN
    localparam logic [CntW-1:0] BncLast = CntW'(BounceCycles - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HOLD,
        S_RELEASE_BOUNCE,
        S_GAP
    } state_t;

    logic [3:0]      r_fifo_code [FifoDepth];
    logic [15:0]     r_fifo_hold [FifoDepth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW:0]   r_count;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic [3:0]      r_code;
    logic [HoldW-1:0] r_hold_last;
    logic            r_pressed;
    logic            r_done;

    state_t          w_state_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [CntW-1:0] w_cnt_inc;
    logic [3:0]      w_code_nxt;
    logic [HoldW-1:0] w_hold_last_nxt;
    logic            w_pressed_nxt;
    logic            w_done_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ready;
    logic [3:0]      w_head_code;
    logic [15:0]     w_head_hold;
    logic [15:0]     w_hold_eff;
    logic [HoldW-1:0] w_hold_cyc;
    logic [1:0]      w_row;
    logic [1:0]      w_col;
    logic [3:0]      w_rows;

    assign w_ready            = (r_count != (PtrW + 1)'(FifoDepth));
    assign key_if.key_ready_o = w_ready;
    assign w_push             = key_if.key_valid_i && w_ready;

    assign w_head_code = r_fifo_code[r_rd_ptr];
    assign w_head_hold = r_fifo_hold[r_rd_ptr];
    assign w_hold_eff  = (w_head_hold == 16'd0) ? 16'd1 : w_head_hold;
    assign w_hold_cyc  = HoldW'(w_hold_eff) * HoldW'(CyclesPerUs);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_code[r_wr_ptr] <= key_if.key_code_i;
            r_fifo_hold[r_wr_ptr] <= key_if.key_hold_us_i;
        end
    end

    // Push and pop may coincide; the count nets them out.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_code      <= '0;
            r_hold_last <= '0;
            r_pressed   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code      <= w_code_nxt;
            r_hold_last <= w_hold_last_nxt;
            r_pressed   <= w_pressed_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_code_nxt      = r_code;
        w_hold_last_nxt = r_hold_last;
        w_pressed_nxt   = r_pressed;
        w_done_nxt      = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop           = 1'b1;
                    w_code_nxt      = w_head_code;
                    w_hold_last_nxt = w_hold_cyc - 1'b1;
                    w_cnt_nxt       = '0;
                    w_pressed_nxt   = 1'b1;
`ifdef KYPD_EMU_BOUNCE_EN
                    w_state_nxt     = S_PRESS_BOUNCE;
`else
                    w_state_nxt     = S_HOLD;
`endif
                end
            end
`ifdef KYPD_EMU_BOUNCE_EN
            S_PRESS_BOUNCE: begin
                if (r_cnt == BncLast) begin
                    w_state_nxt   = S_HOLD;
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt[2:0] == 3'd7) w_pressed_nxt = !r_pressed;
                end
            end
            S_RELEASE_BOUNCE: begin
                if (r_cnt == BncLast) begin
                    w_state_nxt   = S_GAP;
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt[2:0] == 3'd7) w_pressed_nxt = !r_pressed;
                end
            end
`endif
            S_HOLD: begin
                if (r_cnt == CntW'(r_hold_last)) begin
`ifdef KYPD_EMU_BOUNCE_EN
                    w_state_nxt   = S_RELEASE_BOUNCE;
`else
                    w_state_nxt   = S_GAP;
`endif
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_GAP: begin
                if (r_cnt == GapLast) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pressed_nxt = 1'b0;
            end
        endcase
    end

    // Row/column index 0 is row1/col1, which sits on bit 3 of the buses.
    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_code)
            4'h1, 4'h2, 4'h3, 4'hA: w_row = 2'd0;
            4'h4, 4'h5, 4'h6, 4'hB: w_row = 2'd1;
            4'h7, 4'h8, 4'h9, 4'hC: w_row = 2'd2;
            default:                w_row = 2'd3;
        endcase
        case (r_code)
            4'h1, 4'h4, 4'h7, 4'h0: w_col = 2'd0;
            4'h2, 4'h5, 4'h8, 4'hF: w_col = 2'd1;
            4'h3, 4'h6, 4'h9, 4'hE: w_col = 2'd2;
            default:                w_col = 2'd3;
        endcase
    end

    always_comb begin
        w_rows = 4'hF;
        if (r_pressed && !kypd_cols_i[~w_col]) w_rows[~w_row] = 1'b0;
    end

    assign kypd_rows_o = w_rows;
    assign pressed_o   = r_pressed;
    assign done_o      = r_done;
    assign busy_o      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: doc/digilent_kypd_emulator.md
# digilent_kypd_emulator

Behavioural-grade synthesizable model of the Digilent PMOD KYPD matrix keypad, i.e. the keypad end of the column-scan/row-sense interface. It accepts key-press commands (key code + hold time) through a valid/ready queue. It closes the corresponding matrix contact for the commanded time, so that rows respond to the scanner's active-low column drive exactly as the real keypad does. It is used in simulation and on-board loopback to drive `digilent_kypd_decoder` without physical keys.

## Interface
- `ClockFrequencyInMHz`, 100.0, clock frequency; must be an integer value ≥ 1 (`CyclesPerUs = int'(ClockFrequencyInMHz)`).
- `ReleaseGapCycles`, 1000, contact-open cycles enforced between consecutive presses (≥ 1).
- `BounceCycles`, 64, bounce window length in cycles (used only with bounce enabled; multiple of 8, ≥ 8).
- `FifoDepth`, 4, command queue depth (power of two, ≥ 2).
- `clk_i` in 1 system clock.
- `reset_i` in 1 reset; one clock; asynchronous, active-high.
- `kypd_cols_i` in 4 column drive from scanner, active-low; bit3 = column 1 … bit0 = column 4.
- `kypd_rows_o` out 4 row sense, active-low; bit3 = row 1 … bit0 = row 4.
- `key_valid_i` in 1 command valid.
- `key_ready_o` out 1 queue can accept (= not full).
- `key_code_i` in 4 hex key code.
- `key_hold_us_i` in 16 contact-closed time in µs.
- `pressed_o` out 1 current contact state (1 = closed).
- `busy_o` out 1 FSM not IDLE or queue non-empty.
- `done_o` out 1 one-cycle pulse when a command's release gap completes.

## Operation
- Key matrix (row1..row4): col1 = 1,4,7,0; col2 = 2,5,8,F; col3 = 3,6,9,E; col4 = A,B,C,D.
- Command is accepted on a rising edge with `key_valid_i && key_ready_o`. It is written to the FIFO, and `key_ready_o = 0` while the FIFO holds `FifoDepth` entries.
- FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
  - IDLE: FIFO non-empty → pop, latch code/hold, go to PRESS_BOUNCE (to HOLD when bounce compiled out). Contact closes on the same edge.
  - HOLD: contact closed for `max(hold_us,1) * CyclesPerUs` cycles. `hold_us = 0` is treated as 1. Then go to RELEASE_BOUNCE (to GAP when bounce compiled out) and open the contact.
  - GAP: contact open for `ReleaseGapCycles` cycles. Then go to IDLE with `done_o` pulsed for one cycle.
- Hold counter width: `$clog2(65535*CyclesPerUs+1)`. The counter saturates, with no wrap.
- Row drive is combinational from the registered contact state. A row bit is 0 iff the contact is closed, the latched key lies in that row, and that key's column bit in `kypd_cols_i` is 0. All other row bits are 1. The response to any low column is independent of one-hot-ness.
- Push while the FSM pops in the same cycle is allowed. Occupancy is unchanged, and a pop is never blocked by a push.

## Timing
- Reset values: `kypd_rows_o = 4'hF`, `pressed_o = 0`, `busy_o = 0`, `done_o = 0`, `key_ready_o = 1`. The FIFO is emptied and the FSM goes to IDLE.
- Accept with the FSM idle and the FIFO empty: the write happens at edge N, the pop and contact close at edge N+1, and `pressed_o` is high from N+1.
- `pressed_o` high time without bounce: exactly `max(hold,1)*CyclesPerUs` cycles. The next press starts no earlier than 1 cycle after `done_o`.
- `kypd_rows_o` follows `kypd_cols_i` with zero cycles of latency.
- Reset mid-operation (any state): outputs take their reset values immediately. The queued and in-flight commands are discarded, and no `done_o` is issued.

## Configuration
- `KYPD_EMU_BOUNCE_EN` defined: PRESS_BOUNCE and RELEASE_BOUNCE each last `BounceCycles` cycles.
  - The contact toggles every 8 cycles within each window: it starts closed on press and starts open on release.
  - At the end of PRESS_BOUNCE the contact is stable closed and HOLD begins. At the end of RELEASE_BOUNCE the contact is open and GAP begins.
- Not defined: both bounce states are unreachable, the contact changes exactly once per edge of press/release, and `BounceCycles` is ignored.

## Test plan
- Key 5, hold 10, clk 100 MHz, `kypd_cols_i = 4'b1011` → `kypd_rows_o = 4'b1011` and `pressed_o` high for exactly 1000 cycles. With cols `4'b0111`, rows stay `4'hF`.
- Loopback with `digilent_kypd_decoder` (100 MHz, 1 MHz scan): push 1, F, D with hold 20 → decoder `pressed_key_o` takes 1, F, D in order, with three `done_o` pulses.
- First command hold 100, then push back-to-back → 1 popped plus 4 queued accepted. `key_ready_o` falls after the 4th queued entry and rises the cycle after the next pop.
- Hold 0 → `pressed_o` high exactly 100 cycles.
- Reset asserted mid-HOLD with 2 queued → rows `4'hF`, `pressed_o = 0`, and `busy_o = 0` asynchronously. No `done_o`, and no press after reset release.
- `KYPD_EMU_BOUNCE_EN`, `BounceCycles = 64` → `pressed_o` shows 8 toggles in the first 64 cycles, then a stable 1 for the hold, then bounces on release, then the gap.
